// File: rtl/fec_tx_sequencer.sv
// Gearboxes 65-bit transcoded blocks into the 66-slot, 32-bit frame cadence
// expected by the FEC encoder. Upstream underruns are padded with zero blocks.
module fec_tx_sequencer #(
  parameter int UCNT_W = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic [64:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       out_data,
  output logic              out_parity_sel,
  output logic              out_sof,
  output logic [UCNT_W-1:0] underrun_cnt,
  input  logic              clr_stats
);

  localparam logic [6:0]        PARITY_SLOT = 7'd65;
  localparam logic [UCNT_W-1:0] UCNT_ONE    = 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [6:0]         slot_q;
  logic [6:0]         fill_q;
  logic [96:0]        buf_q;
  logic [31:0]        out_data_q;
  logic               out_parity_sel_q;
  logic               out_sof_q;
  logic [UCNT_W-1:0]  ucnt_q;

  logic               data_slot;
  logic               take;
  logic               underrun;
  logic [64:0]        blk;
  logic [96:0]        merged;
  logic [6:0]         fill_d;

  always_comb begin
    data_slot = (state_q == RUN) && (slot_q != PARITY_SLOT);
    take      = data_slot && (fill_q < 7'd32);
    underrun  = take && !in_valid;
    blk       = (take && in_valid) ? in_data : '0;
    // New block lands directly above the bits still waiting in the buffer
    merged    = buf_q | ({32'd0, blk} << fill_q);
    fill_d    = take ? (fill_q + 7'd33) : (fill_q - 7'd32);
  end

  assign in_ready       = take;
  assign out_data       = out_data_q;
  assign out_parity_sel = out_parity_sel_q;
  assign out_sof        = out_sof_q;
  assign underrun_cnt   = ucnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q          <= IDLE;
      slot_q           <= '0;
      fill_q           <= '0;
      buf_q            <= '0;
      out_data_q       <= '0;
      out_parity_sel_q <= 1'b0;
      out_sof_q        <= 1'b0;
      ucnt_q           <= '0;
    end else begin
      if (clr_stats)
        ucnt_q <= underrun ? UCNT_ONE : '0;
      else if (underrun && !(&ucnt_q))
        ucnt_q <= ucnt_q + UCNT_ONE;

      case (state_q)
        IDLE: begin
          out_data_q       <= '0;
          out_parity_sel_q <= 1'b0;
          out_sof_q        <= 1'b0;
          slot_q           <= '0;
          fill_q           <= '0;
          buf_q            <= '0;
          if (en) state_q <= RUN;
        end
        RUN: begin
          out_sof_q <= (slot_q == 7'd0);
          if (data_slot) begin
            out_data_q       <= merged[31:0];
            out_parity_sel_q <= 1'b0;
            buf_q            <= {32'd0, merged[96:32]};
            fill_q           <= fill_d;
            slot_q           <= slot_q + 7'd1;
          end else begin
            // Parity slot: en is only honoured here so frames never truncate
            out_data_q       <= '0;
            out_parity_sel_q <= 1'b1;
            slot_q           <= '0;
            if (!en) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst && state_q == RUN && slot_q == PARITY_SLOT)
      assert (fill_q == 7'd0);
  end

endmodule

// File: tb/tb_fec_tx_sequencer.sv
// Directed-plus-random bench for fec_tx_sequencer; expected words come from
// concatenating each frame's 32 blocks into one bit stream and slicing it.
module tb_fec_tx_sequencer;

  localparam int UCNT_W = 2;
  localparam int UMAX   = (1 << UCNT_W) - 1;

  logic              clk;
  logic              arst;
  logic              en;
  logic [64:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       out_data;
  logic              out_parity_sel;
  logic              out_sof;
  logic [UCNT_W-1:0] underrun_cnt;
  logic              clr_stats;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;

  logic [64:0] fdata  [66];
  logic        fvalid [66];

  fec_tx_sequencer #(.UCNT_W(UCNT_W)) dut (
    .clk            (clk),
    .arst           (arst),
    .en             (en),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_parity_sel (out_parity_sel),
    .out_sof        (out_sof),
    .underrun_cnt   (underrun_cnt),
    .clr_stats      (clr_stats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_frame(input bit all_valid);
    logic [95:0] t;
    for (int s = 0; s < 66; s++) begin
      t = {$urandom, $urandom, $urandom};
      fdata[s]  = t[64:0];
      fvalid[s] = all_valid ? 1'b1 : ($urandom_range(0, 7) != 0);
    end
  endtask

  // Entered at posedge+1 with the DUT about to process slot 0 of a frame.
  task automatic run_frame(input int en_drop, input int clr_slot, input int stop_at,
                           input bit first_chk);
    logic [2079:0] stream;
    logic [31:0]   ew;
    bit            under;
    for (int k = 0; k < 32; k++)
      stream[65*k +: 65] = fvalid[2*k] ? fdata[2*k] : 65'd0;
    for (int s = 0; s < stop_at; s++) begin
      if (s == en_drop) en = 1'b0;
      in_valid  = fvalid[s];
      in_data   = fdata[s];
      clr_stats = (s == clr_slot);
      #1;
      chk($sformatf("in_ready_s%0d", s), {63'd0, in_ready},
          {63'd0, (s % 2 == 0) && (s < 64)});
      under = (s % 2 == 0) && (s < 64) && !fvalid[s];
      if (s == clr_slot) mcnt = under ? 1 : 0;
      else if (under && mcnt != UMAX) mcnt++;
      @(posedge clk);
      #1;
      ew = (s < 65) ? stream[32*s +: 32] : 32'd0;
      chk($sformatf("out_data_s%0d", s), {32'd0, out_data}, {32'd0, ew});
      chk($sformatf("parity_s%0d", s), {63'd0, out_parity_sel}, {63'd0, s == 65});
      chk($sformatf("sof_s%0d", s), {63'd0, out_sof}, {63'd0, s == 0});
      chk($sformatf("ucnt_s%0d", s), {62'd0, underrun_cnt}, 64'(mcnt));
      if (first_chk && s == 0)
        chk("first_word", {32'd0, out_data}, 64'h00000000DDA603D9);
    end
    clr_stats = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"},   {32'd0, out_data},       64'd0);
    chk({tag, "_parity"}, {63'd0, out_parity_sel}, 64'd0);
    chk({tag, "_sof"},    {63'd0, out_sof},        64'd0);
    chk({tag, "_ready"},  {63'd0, in_ready},       64'd0);
  endtask

  initial begin
    arst      = 1'b1;
    en        = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    #3;
    chk_zero_outputs("reset");
    chk("reset_ucnt", {62'd0, underrun_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #2 arst = 1'b0;
    @(posedge clk);
    #1;
    chk_zero_outputs("idle");

    // Basic frame with the reference opening blocks
    en = 1'b1;
    @(posedge clk);
    #1;
    rand_frame(1'b1);
    fdata[0] = {64'h40ea1e77eed301ec, 1'b1};
    fdata[2] = {64'had5a3bf86d9acf5c, 1'b0};
    run_frame(-1, -1, 66, 1'b1);

    // Underrun window across slots 10..13, back-to-back with the previous frame
    rand_frame(1'b1);
    for (int s = 10; s <= 13; s++) fvalid[s] = 1'b0;
    run_frame(-1, -1, 66, 1'b0);
    chk("ucnt_after_underrun", {62'd0, underrun_cnt}, 64'd2);

    // en dropped mid-frame: frame completes, then idles
    rand_frame(1'b0);
    run_frame(20, -1, 66, 1'b0);
    #1;
    chk("idle_ready_after_drop", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk_zero_outputs("idle_after_drop");
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("sof_not_yet", {63'd0, out_sof}, 64'd0);

    // Clear then saturate the counter with five underruns
    rand_frame(1'b1);
    for (int s = 2; s <= 10; s += 2) fvalid[s] = 1'b0;
    run_frame(-1, 1, 66, 1'b0);
    chk("ucnt_saturated", {62'd0, underrun_cnt}, 64'(UMAX));

    // Clear coinciding with an underrun leaves the counter at one
    rand_frame(1'b1);
    fvalid[30] = 1'b0;
    run_frame(-1, 30, 66, 1'b0);
    chk("ucnt_clr_coincide", {62'd0, underrun_cnt}, 64'd1);

    // Asynchronous reset at slot 40
    rand_frame(1'b0);
    run_frame(-1, -1, 40, 1'b0);
    arst = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    chk("midreset_ucnt", {62'd0, underrun_cnt}, 64'd0);
    mcnt = 0;
    #2 arst = 1'b0;
    @(posedge clk);
    #1;
    rand_frame(1'b0);
    run_frame(-1, -1, 66, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
